branch_control_unit: RTL and testbench
======================================

BRANCH_CONTROL_UNIT -- requirements
Module: branch_control_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: Clk (all state on rising edge) and Reset (active-low, asynchronous assert).
REQ-002 Ports (name  direction  width  meaning):
 Clk  in  1  clock
 Reset  in  1  async active-low reset
 Instruction  in  32  IF/ID instruction being decoded
 IsBranch  in  1  branch/jump present in ID, from Comparator Branch
 BranchTaken  in  1  condition true, from Comparator Output
 IDEX_RegWrite  in  1  EX-stage instr writes register
 IDEX_MemRead  in  1  EX-stage instr is a load
 IDEX_WriteReg  in  5  EX-stage destination
 EXMEM_RegWrite  in  1  MEM-stage instr writes register
 EXMEM_MemRead  in  1  MEM-stage instr is a load
 EXMEM_WriteReg  in  5  MEM-stage destination
 PCWrite  out  1  PC may update
 IFIDWrite  out  1  IF/ID may update
 Bubble  out  1  zero ID/EX control fields
 Flush  out  1  clear IF/ID (squash fetched instr)
 PCSrc  out  1  select branch/jump target
 BranchCount  out  16  branches resolved
 TakenCount  out  16  branches taken
 StallCount  out  16  stall cycles inserted

Function
REQ-003 Used operands: rs=Instruction[25:21] for opcodes 000100, 000101, 000001, 000110, 000111, and jr (opcode 000000, funct 001000); rt=Instruction[20:16] additionally for 000100/000101 only; j/jal use none.
REQ-004 A match SHALL require WriteReg equal to a used operand, RegWrite=1, and WriteReg!=0.
REQ-005 Hazard classes, evaluated only when IsBranch=1: LOAD2 = IDEX match with IDEX_MemRead=1; ALU1 = IDEX match with IDEX_MemRead=0; LOAD1 = EXMEM match with EXMEM_MemRead=1. LOAD2 SHALL take priority over ALU1 and LOAD1.
REQ-006 FSM states RUN and HOLD; HOLD SHALL last exactly one cycle, then return to RUN.
REQ-007 In RUN: LOAD2 -> stall this cycle, next state HOLD; ALU1 or LOAD1 -> stall this cycle, stay RUN; no hazard -> resolve this cycle.
REQ-008 In HOLD: stall unconditionally; hazard inputs ignored; next state RUN.
REQ-009 Stall cycle SHALL drive PCWrite=0, IFIDWrite=0, Bubble=1, Flush=0, PCSrc=0.
REQ-010 Resolve cycle SHALL drive PCWrite=1, IFIDWrite=1, Bubble=0, PCSrc=BranchTaken, Flush=BranchTaken.
REQ-011 Cycles with IsBranch=0 in RUN SHALL drive PCWrite=1, IFIDWrite=1, Bubble=0, Flush=0, PCSrc=0.
REQ-012 Outputs SHALL be combinational from state and inputs (zero latency); only the state and counters are registered.
REQ-013 Each resolve cycle SHALL increment BranchCount by 1, and TakenCount by 1 if BranchTaken=1; each stall cycle SHALL increment StallCount by 1.
REQ-014 All counters SHALL saturate at 16'hFFFF and never wrap.
REQ-015 A branch stalled and then resolved SHALL count as exactly one branch.

Reset
REQ-016 While Reset=0: state=RUN; all counters=0; PCWrite=0, IFIDWrite=0, Bubble=0, Flush=0, PCSrc=0.
REQ-017 Reset asserted in HOLD SHALL abort the stall immediately; the first cycle after release SHALL evaluate in RUN.

Structure
REQ-018 Opcode/funct constants (BEQ, BNE, REGIMM, BGTZ, BLEZ, SPECIAL, JR, J, JAL) and the state encoding SHALL reside in the shared MIPS definitions package.
REQ-019 Operand-match/hazard classification SHALL be one combinational sub-module, branch_hazard_detect; the FSM and counters SHALL stay in the top module.

Verification
REQ-020 beq $1,$2 with IDEX lw writing $2 -> 2 stall cycles (PCWrite=0, Bubble=1), then resolve; StallCount=2, BranchCount=1.
REQ-021 bne $3,$4 with IDEX add writing $3, BranchTaken=1 -> 1 stall, then PCSrc=1, Flush=1; TakenCount=1.
REQ-022 bgtz $5 with IDEX writing $0, or writing $6 -> no stall; j with IDEX lw writing $31 -> no stall, PCSrc=1, Flush=1.
REQ-023 Preload StallCount to 16'hFFFE and apply 3 stall cycles -> StallCount holds 16'hFFFF.
REQ-024 Reset asserted during HOLD -> outputs 0 at once; after release, IsBranch=0 gives PCWrite=1 and all counters 0.

Source files
------------

// File: rtl/branch_control_unit_pkg.sv
// Shared MIPS definitions for the branch control unit: opcode/funct constants,
// FSM state encoding, hazard classes and small helper functions.
package branch_control_unit_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } bcu_state_e;

    // STALL1 covers both the EX-stage ALU producer and the MEM-stage load
    typedef enum logic [1:0] {
        HZ_NONE   = 2'b00,
        HZ_STALL1 = 2'b01,
        HZ_LOAD2  = 2'b10
    } hz_class_e;

    function automatic logic reg_match(input logic regwrite, input logic [4:0] writereg,
                                       input logic [4:0] operand, input logic used);
        return used && regwrite && (writereg != 5'd0) && (writereg == operand);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == CNT_MAX) ? value : (value + 16'd1);
    endfunction

endpackage

// File: rtl/branch_control_unit_if.sv
// Pipeline-side bundle of the branch control unit: decode/hazard inputs,
// pipeline control outputs and the statistics counters.
interface branch_control_unit_if;
    logic [31:0] Instruction;
    logic        IsBranch;
    logic        BranchTaken;
    logic        IDEX_RegWrite;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_WriteReg;
    logic        EXMEM_RegWrite;
    logic        EXMEM_MemRead;
    logic [4:0]  EXMEM_WriteReg;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        Bubble;
    logic        Flush;
    logic        PCSrc;
    logic [15:0] BranchCount;
    logic [15:0] TakenCount;
    logic [15:0] StallCount;

    modport master (
        output Instruction, IsBranch, BranchTaken,
        output IDEX_RegWrite, IDEX_MemRead, IDEX_WriteReg,
        output EXMEM_RegWrite, EXMEM_MemRead, EXMEM_WriteReg,
        input  PCWrite, IFIDWrite, Bubble, Flush, PCSrc,
        input  BranchCount, TakenCount, StallCount
    );

    modport slave (
        input  Instruction, IsBranch, BranchTaken,
        input  IDEX_RegWrite, IDEX_MemRead, IDEX_WriteReg,
        input  EXMEM_RegWrite, EXMEM_MemRead, EXMEM_WriteReg,
        output PCWrite, IFIDWrite, Bubble, Flush, PCSrc,
        output BranchCount, TakenCount, StallCount
    );
endinterface

// File: rtl/branch_control_unit_hazard_detect.sv
// Combinational operand-usage decode and hazard classification for a branch
// or jump sitting in ID against the producers in EX and MEM.
module branch_hazard_detect
    import branch_control_unit_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        is_branch,
    input  logic        idex_regwrite,
    input  logic        idex_memread,
    input  logic [4:0]  idex_writereg,
    input  logic        exmem_regwrite,
    input  logic        exmem_memread,
    input  logic [4:0]  exmem_writereg,
    output hz_class_e   hz_class
);

    logic [5:0] opcode_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic [5:0] funct_s;
    logic       use_rs_s;
    logic       use_rt_s;
    logic       idex_hit_s;
    logic       exmem_hit_s;
    logic       unused_s;

    assign opcode_s = instr[31:26];
    assign rs_s     = instr[25:21];
    assign rt_s     = instr[20:16];
    assign funct_s  = instr[5:0];
    assign unused_s = ^instr[15:6];

    // Which register fields the instruction in ID actually reads; j/jal read none
    always_comb begin
        use_rs_s = 1'b0;
        use_rt_s = 1'b0;
        case (opcode_s)
            OP_BEQ, OP_BNE: begin
                use_rs_s = 1'b1;
                use_rt_s = 1'b1;
            end
            OP_REGIMM, OP_BGTZ, OP_BLEZ: begin
                use_rs_s = 1'b1;
                use_rt_s = 1'b0;
            end
            OP_SPECIAL: begin
                use_rs_s = (funct_s == FN_JR);
                use_rt_s = 1'b0;
            end
            default: begin
                use_rs_s = 1'b0;
                use_rt_s = 1'b0;
            end
        endcase
    end

    assign idex_hit_s  = reg_match(idex_regwrite, idex_writereg, rs_s, use_rs_s)
                       | reg_match(idex_regwrite, idex_writereg, rt_s, use_rt_s);
    assign exmem_hit_s = reg_match(exmem_regwrite, exmem_writereg, rs_s, use_rs_s)
                       | reg_match(exmem_regwrite, exmem_writereg, rt_s, use_rt_s);

    // A load in EX needs two bubbles and therefore outranks the one-bubble cases
    always_comb begin
        hz_class = HZ_NONE;
        if (!is_branch) begin
            hz_class = HZ_NONE;
        end else if (idex_hit_s && idex_memread) begin
            hz_class = HZ_LOAD2;
        end else if ((idex_hit_s && !idex_memread) || (exmem_hit_s && exmem_memread)) begin
            hz_class = HZ_STALL1;
        end else begin
            hz_class = HZ_NONE;
        end
    end

endmodule

// File: rtl/branch_control_unit.sv
// Branch control unit: RUN/HOLD stall FSM driving PC/IF-ID/ID-EX control with
// zero-latency outputs, plus saturating branch/taken/stall statistics counters.
module branch_control_unit
    import branch_control_unit_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    branch_control_unit_if.slave bus
);

    bcu_state_e  state_r;
    bcu_state_e  next_state_s;
    hz_class_e   hz_class_s;
    logic        stall_s;
    logic        resolve_s;
    logic        pcwrite_s;
    logic        ifidwrite_s;
    logic        bubble_s;
    logic        flush_s;
    logic        pcsrc_s;
    logic [15:0] branch_cnt_r;
    logic [15:0] taken_cnt_r;
    logic [15:0] stall_cnt_r;

    branch_hazard_detect u_hazard (
        .instr          (bus.Instruction),
        .is_branch      (bus.IsBranch),
        .idex_regwrite  (bus.IDEX_RegWrite),
        .idex_memread   (bus.IDEX_MemRead),
        .idex_writereg  (bus.IDEX_WriteReg),
        .exmem_regwrite (bus.EXMEM_RegWrite),
        .exmem_memread  (bus.EXMEM_MemRead),
        .exmem_writereg (bus.EXMEM_WriteReg),
        .hz_class       (hz_class_s)
    );

    // Next-state and pipeline control; reset gates every output low immediately
    always_comb begin
        next_state_s = ST_RUN;
        stall_s      = 1'b0;
        resolve_s    = 1'b0;
        if (!Reset) begin
            next_state_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (bus.IsBranch) begin
                        case (hz_class_s)
                            HZ_LOAD2: begin
                                stall_s      = 1'b1;
                                next_state_s = ST_HOLD;
                            end
                            HZ_STALL1: stall_s   = 1'b1;
                            HZ_NONE:   resolve_s = 1'b1;
                            default:   stall_s   = 1'b1;
                        endcase
                    end else begin
                        resolve_s = 1'b0;
                    end
                end
                ST_HOLD: begin
                    stall_s      = 1'b1;
                    next_state_s = ST_RUN;
                end
                default: next_state_s = ST_RUN;
            endcase
        end
    end

    // Stall freezes PC and IF/ID and bubbles ID/EX; resolve redirects when taken
    always_comb begin
        pcwrite_s   = 1'b0;
        ifidwrite_s = 1'b0;
        bubble_s    = 1'b0;
        flush_s     = 1'b0;
        pcsrc_s     = 1'b0;
        if (!Reset) begin
            pcwrite_s = 1'b0;
        end else if (stall_s) begin
            bubble_s = 1'b1;
        end else begin
            pcwrite_s   = 1'b1;
            ifidwrite_s = 1'b1;
            pcsrc_s     = resolve_s && bus.BranchTaken;
            flush_s     = resolve_s && bus.BranchTaken;
        end
    end

    // FSM state register; reset aborts a pending HOLD
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Statistics counters; a stalled branch is counted once, when it resolves
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            branch_cnt_r <= 16'd0;
            taken_cnt_r  <= 16'd0;
            stall_cnt_r  <= 16'd0;
        end else begin
            if (resolve_s) begin
                branch_cnt_r <= sat_inc(branch_cnt_r);
            end
            if (resolve_s && bus.BranchTaken) begin
                taken_cnt_r <= sat_inc(taken_cnt_r);
            end
            if (stall_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
        end
    end

    assign bus.PCWrite     = pcwrite_s;
    assign bus.IFIDWrite   = ifidwrite_s;
    assign bus.Bubble      = bubble_s;
    assign bus.Flush       = flush_s;
    assign bus.PCSrc       = pcsrc_s;
    assign bus.BranchCount = branch_cnt_r;
    assign bus.TakenCount  = taken_cnt_r;
    assign bus.StallCount  = stall_cnt_r;

endmodule

// File: tb/tb_branch_control_unit.sv
// Directed bench for branch_control_unit: single-cycle decode table in RUN,
// then hand sequences for load-use hold, ALU stall, reset-in-HOLD and saturation.
module tb_branch_control_unit;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    branch_control_unit_if bus ();

    branch_control_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // out = {PCWrite, IFIDWrite, Bubble, Flush, PCSrc}
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        br;
        logic        tk;
        logic        ex_rw;
        logic        ex_mr;
        logic [4:0]  ex_wr;
        logic        mm_rw;
        logic        mm_mr;
        logic [4:0]  mm_wr;
        logic [4:0]  out;
    } vec_t;

    vec_t vecs[$];

    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_TAKEN = 5'b11011;
    localparam logic [4:0] O_STALL = 5'b00100;
    localparam logic [4:0] O_RST   = 5'b00000;

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0010};
    endfunction

    function automatic vec_t mk(input string name, input logic [31:0] instr, input logic br, input logic tk,
                                input logic ex_rw, input logic ex_mr, input logic [4:0] ex_wr,
                                input logic mm_rw, input logic mm_mr, input logic [4:0] mm_wr,
                                input logic [4:0] out);
        vec_t v;
        v.name = name; v.instr = instr; v.br = br; v.tk = tk;
        v.ex_rw = ex_rw; v.ex_mr = ex_mr; v.ex_wr = ex_wr;
        v.mm_rw = mm_rw; v.mm_mr = mm_mr; v.mm_wr = mm_wr; v.out = out;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.Instruction    = v.instr;
        bus.IsBranch       = v.br;
        bus.BranchTaken    = v.tk;
        bus.IDEX_RegWrite  = v.ex_rw;
        bus.IDEX_MemRead   = v.ex_mr;
        bus.IDEX_WriteReg  = v.ex_wr;
        bus.EXMEM_RegWrite = v.mm_rw;
        bus.EXMEM_MemRead  = v.mm_mr;
        bus.EXMEM_WriteReg = v.mm_wr;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [4:0] exp);
        chk(name, {27'd0, bus.PCWrite, bus.IFIDWrite, bus.Bubble, bus.Flush, bus.PCSrc}, {27'd0, exp});
    endtask

    task automatic chk_cnt(input string name, input logic [15:0] b, input logic [15:0] t, input logic [15:0] s);
        chk({name, ".branch"}, {16'd0, bus.BranchCount}, {16'd0, b});
        chk({name, ".taken"},  {16'd0, bus.TakenCount},  {16'd0, t});
        chk({name, ".stall"},  {16'd0, bus.StallCount},  {16'd0, s});
    endtask

    // Advance one clock and return 1 time unit after the rising edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input vec_t idle);
        drive(idle);
        Reset = 1'b0;
        tick();
        tick();
        #2 Reset = 1'b1;
        tick();
    endtask

    initial begin
        vec_t idle;
        vec_t beq12;
        int   exp_b;
        int   exp_t;
        int   exp_s;

        beq12 = mk("beq", itype(6'b000100, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, O_RUN);
        idle  = mk("idle", 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, O_RUN);

        vecs.push_back(mk("no_branch",     32'h0022_0820,                        1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0, O_RUN));
        vecs.push_back(mk("beq_clean_nt",  itype(6'b000100, 5'd1, 5'd2),         1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0, O_RUN));
        vecs.push_back(mk("beq_clean_tk",  itype(6'b000100, 5'd1, 5'd2),         1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0, O_TAKEN));
        vecs.push_back(mk("bne_alu_rt",    itype(6'b000101, 5'd3, 5'd4),         1'b1, 1'b1, 1'b1, 1'b0, 5'd4,  1'b0, 1'b0, 5'd0, O_STALL));
        vecs.push_back(mk("bgtz_wr_r0",    itype(6'b000111, 5'd5, 5'd0),         1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0, O_TAKEN));
        vecs.push_back(mk("bgtz_wr_r6",    itype(6'b000111, 5'd5, 5'd0),         1'b1, 1'b0, 1'b1, 1'b0, 5'd6,  1'b0, 1'b0, 5'd0, O_RUN));
        vecs.push_back(mk("j_lw_r31",      {6'b000010, 26'h3FF_FFFF},            1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 5'd0, O_TAKEN));
        vecs.push_back(mk("blez_rt_free",  itype(6'b000110, 5'd7, 5'd8),         1'b1, 1'b0, 1'b1, 1'b0, 5'd8,  1'b1, 1'b1, 5'd8, O_RUN));
        vecs.push_back(mk("beq_memlw_rs",  itype(6'b000100, 5'd1, 5'd2),         1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd1, O_STALL));
        vecs.push_back(mk("beq_memalu_rs", itype(6'b000100, 5'd1, 5'd2),         1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 5'd1, O_RUN));
        vecs.push_back(mk("jr_alu_r31",    {6'b000000, 5'd31, 15'd0, 6'b001000}, 1'b1, 1'b1, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 5'd0, O_STALL));
        vecs.push_back(mk("beq_no_rw",     itype(6'b000100, 5'd1, 5'd2),         1'b1, 1'b0, 1'b0, 1'b1, 5'd2,  1'b0, 1'b1, 5'd2, O_RUN));
        vecs.push_back(mk("nobr_hazard",   itype(6'b000100, 5'd1, 5'd2),         1'b0, 1'b1, 1'b1, 1'b0, 5'd1,  1'b1, 1'b1, 5'd2, O_RUN));
        vecs.push_back(mk("bltz_memlw",    itype(6'b000001, 5'd9, 5'd0),         1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd9, O_STALL));
        vecs.push_back(mk("add_not_jr",    {6'b000000, 5'd10, 15'd0, 6'b100000}, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 1'b0, 1'b0, 5'd0, O_TAKEN));

        // Reset state: outputs low and counters clear even with a hazardous branch applied
        drive(vecs[3]);
        #3;
        chk_out("reset_outputs", O_RST);
        chk_cnt("reset", 16'd0, 16'd0, 16'd0);

        // Decode table, one RUN cycle per entry
        do_reset(idle);
        exp_b = 0; exp_t = 0; exp_s = 0;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            chk_out(vecs[i].name, vecs[i].out);
            if (vecs[i].out[2]) exp_s++;
            else if (vecs[i].br) begin
                exp_b++;
                if (vecs[i].out[1]) exp_t++;
            end
            tick();
        end
        drive(idle);
        #1;
        chk_cnt("table", exp_b[15:0], exp_t[15:0], exp_s[15:0]);

        // beq $1,$2 behind lw $2: two bubbles, then resolve once
        do_reset(idle);
        drive(beq12);
        bus.IDEX_RegWrite = 1'b1; bus.IDEX_MemRead = 1'b1; bus.IDEX_WriteReg = 5'd2;
        #1 chk_out("load2_c1", O_STALL);
        tick();
        drive(beq12);
        #1 chk_out("load2_hold", O_STALL);
        tick();
        #1 chk_out("load2_resolve", O_RUN);
        tick();
        drive(idle);
        #1 chk_cnt("load2", 16'd1, 16'd0, 16'd2);

        // bne $3,$4 behind add $3, taken: one bubble then redirect
        do_reset(idle);
        drive(mk("bne", itype(6'b000101, 5'd3, 5'd4), 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, O_STALL));
        #1 chk_out("alu1_c1", O_STALL);
        tick();
        drive(mk("bne", itype(6'b000101, 5'd3, 5'd4), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd3, O_TAKEN));
        #1 chk_out("alu1_resolve", O_TAKEN);
        tick();
        drive(idle);
        #1 chk_cnt("alu1", 16'd1, 16'd1, 16'd1);

        // Reset while in HOLD: outputs drop at once, first cycle after release is RUN
        do_reset(idle);
        drive(beq12);
        bus.IDEX_RegWrite = 1'b1; bus.IDEX_MemRead = 1'b1; bus.IDEX_WriteReg = 5'd1;
        tick();
        drive(beq12);
        #1 chk_out("hold_before_rst", O_STALL);
        Reset = 1'b0;
        #1 chk_out("rst_in_hold", O_RST);
        chk_cnt("rst_in_hold", 16'd0, 16'd0, 16'd0);
        tick();
        #2 Reset = 1'b1;
        drive(idle);
        #1 chk_out("post_rst_idle", O_RUN);
        chk_cnt("post_rst", 16'd0, 16'd0, 16'd0);
        drive(beq12);
        #1 chk_out("post_rst_run", O_RUN);

        // Stall counter saturation
        do_reset(idle);
        drive(mk("jr", {6'b000000, 5'd31, 15'd0, 6'b001000}, 1'b1, 1'b0, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 5'd0, O_STALL));
        for (int i = 0; i < 65534; i++) tick();
        chk_cnt("sat_fffe", 16'd0, 16'd0, 16'hFFFE);
        for (int i = 0; i < 3; i++) tick();
        chk_cnt("sat_ffff", 16'd0, 16'd0, 16'hFFFF);
        chk_out("sat_stall", O_STALL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
